// File: rtl/eth_multi_ch_traffic_tester.sv
// eth_multi_ch_traffic_tester
// N-channel AXI-Stream frame generator and loopback checker. Each channel sends
// sequence-numbered frames whose length sweeps MIN..MAX, and checks the looped-back
// stream for data, keep, length, tuser and sequence errors.
module eth_multi_ch_traffic_tester #(
  parameter int          P_CHANNEL_NUM = 2,
  parameter logic [14:0] P_MIN_LENGTH  = 15'd64,
  parameter logic [14:0] P_MAX_LENGTH  = 15'd9600,
  parameter logic [14:0] P_LEN_STEP    = 15'd1,
  parameter logic [7:0]  P_IFG         = 8'd12
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_CHANNEL_NUM-1:0]     i_enable,
  output logic [P_CHANNEL_NUM*64-1:0]  o_tx_axis_tdata,
  output logic [P_CHANNEL_NUM*8-1:0]   o_tx_axis_tkeep,
  output logic [P_CHANNEL_NUM-1:0]     o_tx_axis_tvalid,
  output logic [P_CHANNEL_NUM-1:0]     o_tx_axis_tlast,
  input  logic [P_CHANNEL_NUM-1:0]     i_tx_axis_tready,
  input  logic [P_CHANNEL_NUM*64-1:0]  i_rx_axis_tdata,
  input  logic [P_CHANNEL_NUM*8-1:0]   i_rx_axis_tkeep,
  input  logic [P_CHANNEL_NUM-1:0]     i_rx_axis_tvalid,
  input  logic [P_CHANNEL_NUM-1:0]     i_rx_axis_tlast,
  input  logic [P_CHANNEL_NUM-1:0]     i_rx_axis_tuser,
  output logic [P_CHANNEL_NUM*32-1:0]  o_tx_frame_cnt,
  output logic [P_CHANNEL_NUM*32-1:0]  o_rx_frame_cnt,
  output logic [P_CHANNEL_NUM*16-1:0]  o_err_cnt,
  output logic [P_CHANNEL_NUM*16-1:0]  o_seq_err_cnt,
  output logic [P_CHANNEL_NUM-1:0]     o_pass
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tx_state_t;

  // Length of the frame following one of length len, wrapping to the minimum.
  function automatic logic [14:0] next_len(input logic [14:0] len);
    logic [15:0] sum;
    sum = {1'b0, len} + {1'b0, P_LEN_STEP};
    if (sum > {1'b0, P_MAX_LENGTH}) next_len = P_MIN_LENGTH;
    else next_len = sum[14:0];
  endfunction

  // Index of the final beat of a len-byte frame, i.e. ceil(len/8)-1.
  function automatic logic [15:0] last_beat_idx(input logic [14:0] len);
    logic [15:0] beats;
    beats = ({1'b0, len} + 16'd7) >> 3;
    last_beat_idx = beats - 16'd1;
  endfunction

  // Byte enables of the final beat of a len-byte frame.
  function automatic logic [7:0] last_keep(input logic [14:0] len);
    if (len[2:0] == 3'd0) last_keep = 8'hFF;
    else last_keep = 8'hFF >> (4'd8 - {1'b0, len[2:0]});
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (&v) ? v : v + 16'd1;
  endfunction

  for (genvar c = 0; c < P_CHANNEL_NUM; c++) begin : g_ch
    tx_state_t   tx_state;
    logic        tx_valid;
    logic [15:0] tx_seq;
    logic [15:0] tx_beat;
    logic [14:0] tx_len;
    logic [7:0]  gap_cnt;
    logic [31:0] tx_cnt;
    logic        tx_last;

    logic [63:0] rx_data;
    logic [7:0]  rx_keep;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_user;
    logic        rx_in_frame;
    logic        rx_seen;
    logic [15:0] rx_seq;
    logic [15:0] rx_beat;
    logic [15:0] rx_exp_seq;
    logic [14:0] rx_exp_len;
    logic        rx_frame_err;
    logic [31:0] rx_cnt;
    logic [15:0] err_cnt;
    logic [15:0] seq_err_cnt;
    logic        pass;
    logic [15:0] cur_seq;
    logic [15:0] cur_beat;
    logic        beat_bad;
    logic        seq_bad;

    assign tx_last = (tx_beat == last_beat_idx(tx_len));

    // TX generator: IDLE waits for enable, SEND streams one frame, GAP inserts the IFG.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        tx_state <= ST_IDLE;
        tx_valid <= 1'b0;
        tx_seq   <= 16'd0;
        tx_beat  <= 16'd0;
        tx_len   <= P_MIN_LENGTH;
        gap_cnt  <= 8'd0;
        tx_cnt   <= 32'd0;
      end else begin
        case (tx_state)
          ST_IDLE: begin
            if (i_enable[c]) begin
              tx_state <= ST_SEND;
              tx_valid <= 1'b1;
            end
          end
          ST_SEND: begin
            if (i_tx_axis_tready[c]) begin
              if (tx_last) begin
                tx_cnt  <= sat_inc32(tx_cnt);
                tx_seq  <= tx_seq + 16'd1;
                tx_len  <= next_len(tx_len);
                tx_beat <= 16'd0;
                gap_cnt <= 8'd0;
                if (P_IFG != 8'd0) begin
                  tx_state <= ST_GAP;
                  tx_valid <= 1'b0;
                end else if (i_enable[c]) begin
                  tx_state <= ST_SEND;
                  tx_valid <= 1'b1;
                end else begin
                  tx_state <= ST_IDLE;
                  tx_valid <= 1'b0;
                end
              end else begin
                tx_beat <= tx_beat + 16'd1;
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt == P_IFG - 8'd1) begin
              gap_cnt <= 8'd0;
              if (i_enable[c]) begin
                tx_state <= ST_SEND;
                tx_valid <= 1'b1;
              end else begin
                tx_state <= ST_IDLE;
              end
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          default: begin
            tx_state <= ST_IDLE;
            tx_valid <= 1'b0;
          end
        endcase
      end
    end

    assign o_tx_axis_tvalid[c]       = tx_valid;
    assign o_tx_axis_tdata[c*64+:64] = tx_valid ? {tx_seq, tx_beat, ~tx_seq, ~tx_beat} : 64'd0;
    assign o_tx_axis_tkeep[c*8+:8]   = tx_valid ? (tx_last ? last_keep(tx_len) : 8'hFF) : 8'h00;
    assign o_tx_axis_tlast[c]        = tx_valid & tx_last;
    assign o_tx_frame_cnt[c*32+:32]  = tx_cnt;

    assign rx_data  = i_rx_axis_tdata[c*64+:64];
    assign rx_keep  = i_rx_axis_tkeep[c*8+:8];
    assign rx_valid = i_rx_axis_tvalid[c];
    assign rx_last  = i_rx_axis_tlast[c];
    assign rx_user  = i_rx_axis_tuser[c];

    // Per-beat check: the first beat supplies its own sequence number, later beats use the stored one.
    always_comb begin
      cur_seq  = rx_in_frame ? rx_seq : rx_data[63:48];
      cur_beat = rx_in_frame ? rx_beat : 16'd0;
      beat_bad = (rx_data != {cur_seq, cur_beat, ~cur_seq, ~cur_beat});
      if (rx_last) begin
        beat_bad = beat_bad | (cur_beat != last_beat_idx(rx_exp_len))
                            | (rx_keep != last_keep(rx_exp_len)) | rx_user;
      end else begin
        beat_bad = beat_bad | (rx_keep != 8'hFF);
      end
      seq_bad = !rx_in_frame && rx_seen && (rx_data[63:48] != rx_exp_seq);
    end

    // RX checker state, error accumulation and saturating counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rx_in_frame  <= 1'b0;
        rx_seen      <= 1'b0;
        rx_seq       <= 16'd0;
        rx_beat      <= 16'd0;
        rx_exp_seq   <= 16'd0;
        rx_exp_len   <= P_MIN_LENGTH;
        rx_frame_err <= 1'b0;
        rx_cnt       <= 32'd0;
        err_cnt      <= 16'd0;
        seq_err_cnt  <= 16'd0;
        pass         <= 1'b0;
      end else begin
        if (rx_valid) begin
          if (!rx_in_frame) begin
            rx_seq     <= rx_data[63:48];
            rx_exp_seq <= rx_data[63:48] + 16'd1;
            rx_seen    <= 1'b1;
            if (seq_bad) seq_err_cnt <= sat_inc16(seq_err_cnt);
          end
          if (rx_last) begin
            rx_in_frame  <= 1'b0;
            rx_beat      <= 16'd0;
            rx_frame_err <= 1'b0;
            rx_cnt       <= sat_inc32(rx_cnt);
            rx_exp_len   <= next_len(rx_exp_len);
            if (rx_frame_err || beat_bad) err_cnt <= sat_inc16(err_cnt);
          end else begin
            rx_in_frame  <= 1'b1;
            rx_beat      <= cur_beat + 16'd1;
            rx_frame_err <= rx_frame_err | beat_bad;
          end
        end
        pass <= (rx_cnt != 32'd0) && (err_cnt == 16'd0) && (seq_err_cnt == 16'd0);
      end
    end

    assign o_rx_frame_cnt[c*32+:32] = rx_cnt;
    assign o_err_cnt[c*16+:16]      = err_cnt;
    assign o_seq_err_cnt[c*16+:16]  = seq_err_cnt;
    assign o_pass[c]                = pass;
  end

endmodule

// File: tb/tb_eth_multi_ch_traffic_tester.sv
// Bench for eth_multi_ch_traffic_tester: two channels on the default sweep plus a
// second single-channel instance with a short 64/72/8 sweep, TX looped back to RX
// through a fault-injection path.
module tb_eth_multi_ch_traffic_tester;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] en, rdy;
  logic [1:0] drop_en, corrupt_en, tuser_en;
  logic [15:0] drop_seq, corrupt_seq, corrupt_beat, tuser_seq;
  int total, bad;

  logic [127:0] a_tdata, a_rdata;
  logic [15:0]  a_tkeep, a_rkeep;
  logic [1:0]   a_tvalid, a_tlast, a_rvalid, a_rlast, a_ruser, a_pass;
  logic [63:0]  a_txc, a_rxc;
  logic [31:0]  a_err, a_seq;

  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;
  logic [0:0]  b_tvalid, b_tlast, b_rvalid, b_pass, b_ruser;
  logic [31:0] b_txc, b_rxc;
  logic [15:0] b_err, b_seq;

  eth_multi_ch_traffic_tester dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en[1:0]),
    .o_tx_axis_tdata(a_tdata), .o_tx_axis_tkeep(a_tkeep), .o_tx_axis_tvalid(a_tvalid),
    .o_tx_axis_tlast(a_tlast), .i_tx_axis_tready(rdy[1:0]),
    .i_rx_axis_tdata(a_rdata), .i_rx_axis_tkeep(a_rkeep), .i_rx_axis_tvalid(a_rvalid),
    .i_rx_axis_tlast(a_rlast), .i_rx_axis_tuser(a_ruser),
    .o_tx_frame_cnt(a_txc), .o_rx_frame_cnt(a_rxc), .o_err_cnt(a_err),
    .o_seq_err_cnt(a_seq), .o_pass(a_pass)
  );

  eth_multi_ch_traffic_tester #(
    .P_CHANNEL_NUM(1), .P_MIN_LENGTH(15'd64), .P_MAX_LENGTH(15'd72), .P_LEN_STEP(15'd8), .P_IFG(8'd12)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en[2:2]),
    .o_tx_axis_tdata(b_tdata), .o_tx_axis_tkeep(b_tkeep), .o_tx_axis_tvalid(b_tvalid),
    .o_tx_axis_tlast(b_tlast), .i_tx_axis_tready(rdy[2:2]),
    .i_rx_axis_tdata(b_tdata), .i_rx_axis_tkeep(b_tkeep), .i_rx_axis_tvalid(b_rvalid),
    .i_rx_axis_tlast(b_tlast), .i_rx_axis_tuser(b_ruser),
    .o_tx_frame_cnt(b_txc), .o_rx_frame_cnt(b_rxc), .o_err_cnt(b_err),
    .o_seq_err_cnt(b_seq), .o_pass(b_pass)
  );

  assign b_rvalid = b_tvalid & rdy[2:2];
  assign b_ruser  = 1'b0;

  // Loopback with optional frame drop, bit-5 corruption and tuser injection.
  for (genvar c = 0; c < 2; c++) begin : g_loop
    logic [63:0] d;
    assign d = a_tdata[c*64+:64];
    assign a_rvalid[c] = a_tvalid[c] & rdy[c] & ~(drop_en[c] & (d[63:48] == drop_seq));
    assign a_rdata[c*64+:64] = d ^ ((corrupt_en[c] && d[63:48] == corrupt_seq && d[47:32] == corrupt_beat)
                                    ? 64'h20 : 64'h0);
    assign a_rkeep[c*8+:8] = a_tkeep[c*8+:8];
    assign a_rlast[c] = a_tlast[c];
    assign a_ruser[c] = tuser_en[c] & a_tlast[c] & (d[63:48] == tuser_seq);
  end

  // Lane view: lanes 0/1 are dut channels, lane 2 is dut_b.
  logic [63:0] l_data[3];
  logic [7:0]  l_keep[3];
  logic        l_valid[3], l_last[3], l_pass[3];
  logic [31:0] l_txc[3], l_rxc[3];
  logic [15:0] l_err[3], l_seq[3];
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      l_data[c] = a_tdata[c*64+:64]; l_keep[c] = a_tkeep[c*8+:8];
      l_valid[c] = a_tvalid[c]; l_last[c] = a_tlast[c]; l_pass[c] = a_pass[c];
      l_txc[c] = a_txc[c*32+:32]; l_rxc[c] = a_rxc[c*32+:32];
      l_err[c] = a_err[c*16+:16]; l_seq[c] = a_seq[c*16+:16];
    end
    l_data[2] = b_tdata; l_keep[2] = b_tkeep; l_valid[2] = b_tvalid[0]; l_last[2] = b_tlast[0];
    l_pass[2] = b_pass[0]; l_txc[2] = b_txc; l_rxc[2] = b_rxc; l_err[2] = b_err; l_seq[2] = b_seq;
  end

  // Frame length of the k-th frame after reset on a lane.
  function automatic int len_of(input int l, input int k);
    int mn, mx, st, n;
    if (l == 2) begin mn = 64; mx = 72; st = 8; end
    else begin mn = 64; mx = 9600; st = 1; end
    n = (mx - mn) / st + 1;
    return mn + (k % n) * st;
  endfunction

  int          m_frame[3], m_beat[3], gap_cnt[3], last_gap[3];
  bit          gap_act[3];
  int          beats_seen[3][16];
  logic [7:0]  keep_seen[3][16];

  // TX monitor: every valid cycle must present the beat the model expects; IFG measured per lane.
  always @(negedge clk) begin : mon
    int k, len, nb, b;
    logic [15:0] s, bw;
    logic [63:0] e_data;
    logic [7:0]  e_keep;
    logic        e_last;
    for (int l = 0; l < 3; l++) begin
      if (rst) begin
        m_frame[l] = 0; m_beat[l] = 0; gap_cnt[l] = 0; gap_act[l] = 0; last_gap[l] = -1;
      end else if (l_valid[l]) begin
        if (gap_act[l]) begin
          total++;
          if (gap_cnt[l] != 12) begin
            bad++;
            $display("[TB] FAIL ifg lane%0d got=%0d want=12", l, gap_cnt[l]);
          end
          last_gap[l] = gap_cnt[l];
          gap_act[l] = 0;
        end
        k = m_frame[l]; len = len_of(l, k); nb = (len + 7) / 8; b = m_beat[l];
        s = k[15:0]; bw = b[15:0];
        e_data = {s, bw, ~s, ~bw};
        e_last = (b == nb - 1);
        e_keep = e_last ? ((len % 8 == 0) ? 8'hFF : (8'hFF >> (8 - len % 8))) : 8'hFF;
        total++;
        if ({l_data[l], l_keep[l], l_last[l]} !== {e_data, e_keep, e_last}) begin
          bad++;
          $display("[TB] FAIL tx_beat lane%0d frame%0d beat%0d got=%h/%h/%b want=%h/%h/%b",
                   l, k, b, l_data[l], l_keep[l], l_last[l], e_data, e_keep, e_last);
        end
        if (rdy[l]) begin
          if (l_last[l]) begin
            if (k < 16) begin beats_seen[l][k] = b + 1; keep_seen[l][k] = l_keep[l]; end
            m_frame[l]++; m_beat[l] = 0; gap_act[l] = 1; gap_cnt[l] = 0;
          end else begin
            m_beat[l]++;
          end
        end
      end else if (gap_act[l]) begin
        gap_cnt[l]++;
      end
    end
  end

  task automatic do_reset();
    en = 0; rdy = 0; drop_en = 0; corrupt_en = 0; tuser_en = 0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs n frames on the selected lanes; enable is dropped while the last frame is in flight.
  task automatic run_frames(input int n, input logic [2:0] lanes, input bit rnd);
    int cyc;
    bit done;
    en = lanes; cyc = 0; done = 0;
    while (!done && cyc < 30000) begin
      @(posedge clk); #1;
      cyc++;
      for (int l = 0; l < 3; l++) begin
        rdy[l] = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (en[l] && m_frame[l] == n - 1 && l_valid[l]) en[l] = 1'b0;
      end
      done = (en == 3'b000) && !l_valid[0] && !l_valid[1] && !l_valid[2];
    end
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL run_timeout got=%0d cycles want=done", cyc);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      total++;
      if ({l_valid[l], l_last[l], l_keep[l], l_data[l]} !== 74'd0) begin
        bad++;
        $display("[TB] FAIL reset_tx lane%0d got=%b/%b/%h/%h want=0", l, l_valid[l], l_last[l], l_keep[l], l_data[l]);
      end
      total++;
      if ({l_txc[l], l_rxc[l], l_err[l], l_seq[l], l_pass[l]} !== 97'd0) begin
        bad++;
        $display("[TB] FAIL reset_cnt lane%0d got=%0d/%0d/%0d/%0d/%b want=0",
                 l, l_txc[l], l_rxc[l], l_err[l], l_seq[l], l_pass[l]);
      end
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    run_frames(10, 3'b011, 1'b0);
    for (int l = 0; l < 2; l++) begin
      total++;
      if (l_txc[l] !== 32'd10 || l_rxc[l] !== 32'd10) begin
        bad++;
        $display("[TB] FAIL basic_counts lane%0d got=%0d/%0d want=10/10", l, l_txc[l], l_rxc[l]);
      end
      total++;
      if (l_err[l] !== 16'd0 || l_seq[l] !== 16'd0 || l_pass[l] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL basic_status lane%0d got=%0d/%0d/%b want=0/0/1", l, l_err[l], l_seq[l], l_pass[l]);
      end
      total++;
      if (beats_seen[l][9] != (len_of(l, 9) + 7) / 8 || keep_seen[l][9] !== 8'h01) begin
        bad++;
        $display("[TB] FAIL basic_frame9 lane%0d got=%0d/%h want=%0d/01", l, beats_seen[l][9], keep_seen[l][9],
                 (len_of(l, 9) + 7) / 8);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    n = $urandom_range(4, 7);
    do_reset();
    run_frames(n, 3'b011, 1'b1);
    for (int l = 0; l < 2; l++) begin
      total++;
      if (l_txc[l] != n || l_rxc[l] != n || l_err[l] !== 16'd0 || l_seq[l] !== 16'd0 || l_pass[l] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_status lane%0d got=%0d/%0d/%0d/%0d/%b want=%0d/%0d/0/0/1",
                 l, l_txc[l], l_rxc[l], l_err[l], l_seq[l], l_pass[l], n, n);
      end
    end
    total++;
    if (beats_seen[0][0] != 8 || beats_seen[0][1] != 9 || keep_seen[0][1] !== 8'h01) begin
      bad++;
      $display("[TB] FAIL bp_beats got=%0d/%0d/%h want=8/9/01", beats_seen[0][0], beats_seen[0][1], keep_seen[0][1]);
    end
  endtask

  task automatic test_seq_gap();
    int rcv[$];
    int exp_err, exp_seq, d;
    d = $urandom_range(2, 5);
    do_reset();
    drop_seq = d[15:0]; drop_en = 2'b01;
    run_frames(8, 3'b011, 1'b0);
    for (int k = 0; k < 8; k++) if (k != d) rcv.push_back(k);
    exp_err = 0; exp_seq = 0;
    for (int i = 0; i < rcv.size(); i++) begin
      if (len_of(0, rcv[i]) != len_of(0, i)) exp_err++;
      if (i > 0 && rcv[i] != rcv[i-1] + 1) exp_seq++;
    end
    total++;
    if (l_txc[0] != 8 || l_rxc[0] != 7 || l_seq[0] != exp_seq || l_err[0] != exp_err || l_pass[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL gap_ch0 drop=%0d got=%0d/%0d/%0d/%0d/%b want=8/7/%0d/%0d/0",
               d, l_txc[0], l_rxc[0], l_seq[0], l_err[0], l_pass[0], exp_seq, exp_err);
    end
    total++;
    if (l_rxc[1] != 8 || l_err[1] !== 16'd0 || l_seq[1] !== 16'd0 || l_pass[1] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL gap_ch1 got=%0d/%0d/%0d/%b want=8/0/0/1", l_rxc[1], l_err[1], l_seq[1], l_pass[1]);
    end
  endtask

  task automatic test_corrupt();
    int f, g, cb;
    f = $urandom_range(1, 5);
    g = $urandom_range(0, 6);
    cb = $urandom_range(0, (len_of(0, f) + 7) / 8 - 1);
    do_reset();
    corrupt_seq = f[15:0]; corrupt_beat = cb[15:0]; corrupt_en = 2'b01;
    tuser_seq = g[15:0]; tuser_en = 2'b10;
    run_frames(7, 3'b011, 1'b1);
    for (int l = 0; l < 2; l++) begin
      total++;
      if (l_rxc[l] != 7 || l_err[l] != 1 || l_seq[l] !== 16'd0 || l_pass[l] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL corrupt lane%0d frame=%0d/%0d beat=%0d got=%0d/%0d/%0d/%b want=7/1/0/0",
                 l, f, g, cb, l_rxc[l], l_err[l], l_seq[l], l_pass[l]);
      end
    end
  endtask

  task automatic test_len_wrap();
    do_reset();
    run_frames(4, 3'b100, 1'b0);
    total++;
    if (l_txc[2] != 4 || l_rxc[2] != 4 || l_err[2] !== 16'd0 || l_seq[2] !== 16'd0 || l_pass[2] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_status got=%0d/%0d/%0d/%0d/%b want=4/4/0/0/1",
               l_txc[2], l_rxc[2], l_err[2], l_seq[2], l_pass[2]);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (beats_seen[2][k] != (len_of(2, k) + 7) / 8 || keep_seen[2][k] !== 8'hFF) begin
        bad++;
        $display("[TB] FAIL wrap_frame%0d got=%0d/%h want=%0d/ff", k, beats_seen[2][k], keep_seen[2][k],
                 (len_of(2, k) + 7) / 8);
      end
    end
    total++;
    if (last_gap[2] != 12) begin
      bad++;
      $display("[TB] FAIL wrap_ifg got=%0d want=12", last_gap[2]);
    end
  endtask

  task automatic test_reset_midframe();
    int cyc;
    bit seen_valid;
    do_reset();
    rdy = 3'b011; en = 3'b011; cyc = 0;
    while (!(m_frame[0] == 1 && m_beat[0] == 3) && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
    end
    #2 rst = 1'b1;
    #1;
    for (int l = 0; l < 2; l++) begin
      total++;
      if (l_valid[l] !== 1'b0 || l_data[l] !== 64'd0 || l_txc[l] !== 32'd0 || l_rxc[l] !== 32'd0 || l_pass[l] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midreset lane%0d got=%b/%h/%0d/%0d/%b want=0", l, l_valid[l], l_data[l],
                 l_txc[l], l_rxc[l], l_pass[l]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    cyc = 0;
    while (!(m_frame[0] == 1 && m_beat[0] == 2 && l_valid[0]) && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
    end
    en = 3'b000; cyc = 0;
    while ((l_valid[0] || l_valid[1]) && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
    end
    seen_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (l_valid[0] || l_valid[1]) seen_valid = 1;
    end
    for (int l = 0; l < 2; l++) begin
      total++;
      if (l_txc[l] != 2 || l_rxc[l] != 2 || l_pass[l] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL disable_finish lane%0d got=%0d/%0d/%b want=2/2/1", l, l_txc[l], l_rxc[l], l_pass[l]);
      end
    end
    total++;
    if (seen_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL disable_idle got=%b want=0", seen_valid);
    end
  endtask

  initial begin
    rst = 1'b1; en = 0; rdy = 0; drop_en = 0; corrupt_en = 0; tuser_en = 0;
    drop_seq = 0; corrupt_seq = 0; corrupt_beat = 0; tuser_seq = 0;
    total = 0; bad = 0;
    $display("[TB] starting");
    test_reset();
    test_basic();
    test_backpressure();
    test_seq_gap();
    test_corrupt();
    test_len_wrap();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
